// File: rtl/approx_mul_scheduler_pkg.sv
// Shared types and widths for the approximate-multiplier scheduler.
//   state_e : scheduler FSM states (IDLE=0, MUL=1, RESP=2)
//   OPW     : operand width
//   PW      : product width
package approx_mul_scheduler_pkg;

  localparam int unsigned OPW = 16;
  localparam int unsigned PW  = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/approx_mul_scheduler_if.sv
// Request/response bus between NREQ requesters and the multiplier scheduler.
//   req_valid/req_ready : per-requester handshake, req_ready is one-hot
//   req_a/req_b         : packed operands, requester i owns bits [OPW*i +: OPW]
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id/rsp_p        : requester index and product of the returned result
// master: the requester/consumer side.  slave: the scheduler.
interface approx_mul_scheduler_if
  import approx_mul_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [PW-1:0]       rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/approx_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr_i, wrapping.
//   req_i : request vector
//   ptr_i : highest-priority index
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : encoded grant index
//   any_o : at least one request pending
module approx_mul_scheduler_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    any_o = |req_i;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/approx_mul_scheduler.sv
// Shares one external combinational 16x16 multiplier between NREQ requesters.
// Round-robin accept in IDLE, one cycle of stable operands in MUL, then the product
// and requester ID are held in RESP until the consumer takes them.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   bus_io   : request/response bus (slave modport)
//   mul_a_o  : registered operand A to the multiplier
//   mul_b_o  : registered operand B to the multiplier
//   mul_p_i  : multiplier product
//   busy_o   : high whenever not IDLE
// Optional feature: define APPROX_MUL_ZERO_SKIP_EN to bypass MUL when either granted
// operand is zero (product forced to 0, operand registers left untouched).
module approx_mul_scheduler
  import approx_mul_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  approx_mul_scheduler_if.slave        bus_io,
  output logic [OPW-1:0]               mul_a_o,
  output logic [OPW-1:0]               mul_b_o,
  input  logic [PW-1:0]                mul_p_i,
  output logic                         busy_o
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [OPW-1:0]  mul_a_q, mul_a_d;
  logic [OPW-1:0]  mul_b_q, mul_b_d;
  logic [PW-1:0]   rsp_p_q, rsp_p_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any_req;
  logic [OPW-1:0]  op_a [NREQ];
  logic [OPW-1:0]  op_b [NREQ];
  logic [OPW-1:0]  sel_a, sel_b;
  logic            zero_op;

  approx_mul_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (bus_io.req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_req)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i] = bus_io.req_a[i*OPW +: OPW];
    assign op_b[i] = bus_io.req_b[i*OPW +: OPW];
  end

  assign sel_a = op_a[gnt_idx];
  assign sel_b = op_b[gnt_idx];

`ifdef APPROX_MUL_ZERO_SKIP_EN
  assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = zero_op ? StResp : StMul;
      StMul:   state_d = StResp;
      StResp:  if (bus_io.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus_io.req_ready = (state_q == StIdle) ? gnt : '0;
    bus_io.rsp_valid = (state_q == StResp);
    bus_io.rsp_id    = id_q;
    bus_io.rsp_p     = rsp_p_q;
    busy_o           = (state_q != StIdle);
    mul_a_o          = mul_a_q;
    mul_b_o          = mul_b_q;
  end

  // Datapath next-state
  always_comb begin
    rr_d    = rr_q;
    id_d    = id_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    rsp_p_d = rsp_p_q;
    if (state_q == StIdle && any_req) begin
      id_d = gnt_idx;
      if (32'(gnt_idx) == NREQ - 1) begin
        rr_d = '0;
      end else begin
        rr_d = gnt_idx + IDW'(1);
      end
      if (zero_op) begin
        // Multiplier inputs stay put so it does not toggle.
        rsp_p_d = '0;
      end else begin
        mul_a_d = sel_a;
        mul_b_d = sel_b;
      end
    end
    if (state_q == StMul) begin
      rsp_p_d = mul_p_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      id_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      rsp_p_q <= '0;
    end else begin
      rr_q    <= rr_d;
      id_q    <= id_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      rsp_p_q <= rsp_p_d;
    end
  end

endmodule

// File: tb/tb_approx_mul_scheduler.sv
// Self-checking bench for approx_mul_scheduler with an exact zero-delay multiplier model.
module tb_approx_mul_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic        clk;
  logic        rst;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  approx_mul_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  approx_mul_scheduler #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus_io  (bus),
    .mul_a_o (mul_a),
    .mul_b_o (mul_b),
    .mul_p_i (mul_p),
    .busy_o  (busy)
  );

  assign mul_p = 32'(mul_a) * 32'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  mask;
    int          g;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs [6];
  int   fair_order [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int exp_latency(input logic [15:0] a, input logic [15:0] b);
`ifdef APPROX_MUL_ZERO_SKIP_EN
    if (a == 16'h0 || b == 16'h0) return 1;
`endif
    return 2;
  endfunction

  // One transaction with rsp_ready held high; checks grant, operand registers,
  // latency, product, id, and the return to idle.
  task automatic do_txn(input logic [3:0] mask, input int g, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] p);
    logic [15:0] prev_a;
    int          lat;
    int          want_lat;
    bit          seen;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      bus.req_a[j*16 +: 16] = 16'($urandom_range(1, 65535));
      bus.req_b[j*16 +: 16] = 16'($urandom_range(1, 65535));
    end
    bus.req_a[g*16 +: 16] = a;
    bus.req_b[g*16 +: 16] = b;
    bus.req_valid         = mask;
    bus.rsp_ready         = 1'b1;
    #1;
    prev_a   = mul_a;
    want_lat = exp_latency(a, b);
    chk("txn_ready", bus.req_ready, 64'(1) << g);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      if (c == 1) begin
        chk("txn_mul_a", mul_a, (want_lat == 1) ? prev_a : a);
        chk("txn_ready_off", bus.req_ready, 0);
      end
      if (bus.rsp_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    chk("txn_latency", lat, want_lat);
    chk("txn_rsp_p", bus.rsp_p, p);
    chk("txn_rsp_id", bus.rsp_id, g);
    @(negedge clk);
    #1;
    chk("txn_idle", busy, 0);
  endtask

  initial begin
    bit          ok;
    int          rr_m;
    bit          out_m;
    int          g_m;
    int          acc_c;
    int          lat_m;
    logic [31:0] p_m;
    logic [3:0]  exp_rdy;
    logic [15:0] ga;
    logic [15:0] gb;
    bit          exp_v;

    vecs[0] = '{mask: 4'b0001, g: 0, a: 16'h0004, b: 16'h0002, p: 32'h0000_0008};
    vecs[1] = '{mask: 4'b0010, g: 1, a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE_0001};
    vecs[2] = '{mask: 4'b0100, g: 2, a: 16'h0E01, b: 16'h0000, p: 32'h0000_0000};
    vecs[3] = '{mask: 4'b1001, g: 3, a: 16'hA0A0, b: 16'h0A0A, p: 32'h064C_8640};
    vecs[4] = '{mask: 4'b1001, g: 0, a: 16'hA0A0, b: 16'h0A0A, p: 32'h064C_8640};
    vecs[5] = '{mask: 4'b1100, g: 2, a: 16'h1234, b: 16'h5678, p: 32'h0626_0060};
    fair_order[0] = 0;
    fair_order[1] = 1;
    fair_order[2] = 2;
    fair_order[3] = 3;
    fair_order[4] = 0;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_p", bus.rsp_p, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_busy", busy, 0);

    // Table: single requests, zero operand, wrap from rr=3 to 0
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].mask, vecs[i].g, vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Backpressure: response held for 5 cycles, no accept meanwhile
    @(negedge clk);
    bus.req_a[16 +: 16] = 16'hFFFF;
    bus.req_b[16 +: 16] = 16'hFFFF;
    bus.req_valid       = 4'b0010;
    bus.rsp_ready       = 1'b0;
    #1;
    chk("bp_ready", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk("bp_mul_ready", bus.req_ready, 0);
    chk("bp_mul_valid", bus.rsp_valid, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_p", bus.rsp_p, 32'hFFFE_0001);
      chk("bp_hold_id", bus.rsp_id, 1);
      chk("bp_hold_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    #1;
    chk("bp_release_valid", bus.rsp_valid, 1);
    @(negedge clk);
    #1;
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", bus.rsp_valid, 0);

    // Fairness: all four requesters held valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*16 +: 16] = 16'(i + 1);
      bus.req_b[i*16 +: 16] = 16'd3;
    end
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      wait_ready(ok);
      chk("fair_grant_seen", ok, 1);
      chk("fair_grant", bus.req_ready, 64'(1) << fair_order[i]);
      @(negedge clk);
      #1;
      wait_rsp(ok);
      chk("fair_rsp_seen", ok, 1);
      chk("fair_rsp_id", bus.rsp_id, fair_order[i]);
      chk("fair_rsp_p", bus.rsp_p, (fair_order[i] + 1) * 3);
      @(negedge clk);
      #1;
    end

    // Reset while in MUL
    do_reset();
    bus.req_a[32 +: 16] = 16'h1111;
    bus.req_b[32 +: 16] = 16'h2222;
    bus.req_valid       = 4'b0100;
    bus.rsp_ready       = 1'b1;
    #1;
    chk("rmid_ready", bus.req_ready, 4'b0100);
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    #1;
    chk("rmid_in_mul", busy, 1);
    @(negedge clk);
    #1;
    chk("rmid_rsp_valid", bus.rsp_valid, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_mul_a", mul_a, 0);
    chk("rmid_mul_b", mul_b, 0);
    chk("rmid_rsp_p", bus.rsp_p, 0);
    chk("rmid_rsp_id", bus.rsp_id, 0);
    chk("rmid_req_ready", bus.req_ready, 0);
    rst           = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    chk("rmid_first_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    wait_rsp(ok);
    chk("rmid_rsp_seen", ok, 1);
    chk("rmid_rsp_id0", bus.rsp_id, 0);
    @(negedge clk);

    // Random traffic against a transaction-level model
    do_reset();
    rr_m  = 0;
    out_m = 1'b0;
    g_m   = 0;
    acc_c = 0;
    lat_m = 2;
    p_m   = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) bus.req_valid = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.req_a[j*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
          bus.req_b[j*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = '0;
      g_m     = -1;
      if (!out_m && bus.req_valid != '0) begin
        for (int k = 0; k < 4; k++) begin
          if (g_m < 0 && bus.req_valid[(rr_m + k) % 4]) g_m = (rr_m + k) % 4;
        end
        exp_rdy = 4'(1 << g_m);
      end
      chk("rnd_ready", bus.req_ready, exp_rdy);
      chk("rnd_busy", busy, out_m);
      exp_v = out_m && (cyc - acc_c >= lat_m);
      chk("rnd_rsp_valid", bus.rsp_valid, exp_v);
      if (exp_v) begin
        chk("rnd_rsp_p", bus.rsp_p, p_m);
        chk("rnd_rsp_id", bus.rsp_id, rr_m == 0 ? 3 : rr_m - 1);
        if (bus.rsp_ready) out_m = 1'b0;
      end
      if (g_m >= 0) begin
        ga    = bus.req_a[g_m*16 +: 16];
        gb    = bus.req_b[g_m*16 +: 16];
        p_m   = 32'(ga) * 32'(gb);
        lat_m = exp_latency(ga, gb);
        out_m = 1'b1;
        acc_c = cyc;
        rr_m  = (g_m + 1) % 4;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
